// File: rtl/animador_sprites.sv
// animador_sprites: frame sequencer for the pet animation plus status-bar overlay
// on the OLED byte stream (ROM byte or bar pattern, two-cycle latency).
module animador_sprites #(
  parameter int unsigned N_ESTADOS      = 5,
  parameter int unsigned MAX_QUADROS    = 8,
  parameter int unsigned BYTES_QUADRO   = 1024,
  parameter int unsigned PERIODO_QUADRO = 4194304,
  parameter int unsigned N_BARRAS       = 3,
  parameter int unsigned SEGMENTOS      = 5,
  parameter int unsigned PASSO_NIVEL    = 10,
  parameter int unsigned BARRA_LINHA0   = 8,
  parameter int unsigned BARRA_PASSO    = 10,
  parameter int unsigned BARRA_ALTURA   = 5
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [$clog2(BYTES_QUADRO)-1:0]                       byte_counter,
  input  logic [N_ESTADOS-1:0]                                  estado,
  input  logic [8*N_BARRAS-1:0]                                 niveis,
  input  logic [4*N_ESTADOS-1:0]                                num_quadros,
  input  logic [N_ESTADOS-1:0]                                  modo_unico,
  output logic [$clog2(N_ESTADOS*MAX_QUADROS*BYTES_QUADRO)-1:0] mem_addr,
  input  logic [7:0]                                            mem_data,
  output logic [7:0]                                            data_to_send,
  output logic                                                  quadro_fim
);

  localparam int unsigned ADDR_W = $clog2(N_ESTADOS*MAX_QUADROS*BYTES_QUADRO);
  localparam int unsigned K_W    = (N_ESTADOS > 1) ? $clog2(N_ESTADOS) : 1;
  localparam int unsigned IDX_W  = (MAX_QUADROS > 1) ? $clog2(MAX_QUADROS) : 1;
  localparam int unsigned T_W    = (PERIODO_QUADRO > 1) ? $clog2(PERIODO_QUADRO) : 1;
  localparam int unsigned CNT_W  = 5;

  logic [T_W-1:0]    timer_q, timer_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [K_W-1:0]    prev_k_q, prev_k_d;
  logic              fim_q, fim_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              bar_hit_q, bar_hit_d;
  logic [7:0]        bar_byte_q, bar_byte_d;
  logic [7:0]        data_q, data_d;

  logic [K_W-1:0]    k_s;
  logic [3:0]        nq_s;
  logic [CNT_W-1:0]  cnt_s, idx_ext, idx_prox;
  logic              tick_s, troca_s;

  logic [7:0]        nivel_s, limiar_s;
  int unsigned       row_s, col_s, base_s;

  always_comb begin
    k_s = '0;
    if ($onehot(estado)) begin
      for (int unsigned i = 0; i < N_ESTADOS; i++) begin
        if (estado[i]) k_s = K_W'(i);
      end
    end
  end

  always_comb begin
    nq_s = num_quadros[4*k_s +: 4];
    if (nq_s == 4'd0)
      cnt_s = CNT_W'(1);
    else if ({28'd0, nq_s} > MAX_QUADROS)
      cnt_s = CNT_W'(MAX_QUADROS);
    else
      cnt_s = CNT_W'(nq_s);

    idx_ext = CNT_W'(index_q);
    if (modo_unico[k_s])
      idx_prox = (idx_ext + CNT_W'(1) < cnt_s) ? idx_ext + CNT_W'(1) : idx_ext;
    else
      idx_prox = (idx_ext + CNT_W'(1) >= cnt_s) ? '0 : idx_ext + CNT_W'(1);
  end

  // A state change wins over a coincident tick: both counters restart and no pulse is emitted.
  always_comb begin
    tick_s   = (timer_q == T_W'(PERIODO_QUADRO - 1));
    troca_s  = (k_s != prev_k_q);
    prev_k_d = k_s;
    timer_d  = timer_q + T_W'(1);
    index_d  = index_q;
    fim_d    = 1'b0;
    if (troca_s) begin
      timer_d = '0;
      index_d = '0;
    end else if (tick_s) begin
      timer_d = '0;
      index_d = IDX_W'(idx_prox);
      fim_d   = (idx_prox != idx_ext);
    end
  end

  always_comb begin
    mem_addr_d = ADDR_W'(((32'(k_s) * MAX_QUADROS) + 32'(index_q)) * BYTES_QUADRO
                         + 32'(byte_counter));
  end

  always_comb begin
    row_s      = 32'(byte_counter) >> 3;
    col_s      = 32'(byte_counter) & 32'd7;
    base_s     = 0;
    nivel_s    = '0;
    limiar_s   = '0;
    bar_hit_d  = 1'b0;
    bar_byte_d = '0;
    for (int unsigned b = 0; b < N_BARRAS; b++) begin
      base_s = BARRA_LINHA0 + b * BARRA_PASSO;
      if (!bar_hit_d && row_s >= base_s && row_s < base_s + BARRA_ALTURA &&
          col_s >= 1 && col_s <= SEGMENTOS) begin
        bar_hit_d = 1'b1;
        nivel_s   = niveis[8*b +: 8];
        if (nivel_s > 8'd100) nivel_s = 8'd100;
        limiar_s  = 8'(2 * (SEGMENTOS - col_s) * PASSO_NIVEL);
        if (nivel_s > limiar_s + 8'(PASSO_NIVEL))
          bar_byte_d = 8'hEE;
        else if (nivel_s > limiar_s)
          bar_byte_d = 8'hE0;
        else
          bar_byte_d = 8'h00;
      end
    end
  end

  always_comb begin
    data_d = bar_hit_q ? bar_byte_q : mem_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q    <= '0;
      index_q    <= '0;
      prev_k_q   <= '0;
      fim_q      <= 1'b0;
      mem_addr_q <= '0;
      bar_hit_q  <= 1'b0;
      bar_byte_q <= '0;
      data_q     <= '0;
    end else begin
      timer_q    <= timer_d;
      index_q    <= index_d;
      prev_k_q   <= prev_k_d;
      fim_q      <= fim_d;
      mem_addr_q <= mem_addr_d;
      bar_hit_q  <= bar_hit_d;
      bar_byte_q <= bar_byte_d;
      data_q     <= data_d;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign data_to_send = data_q;
  assign quadro_fim   = fim_q;

endmodule

// File: tb/tb_animador_sprites.sv
// Bench for animador_sprites: directed scenarios plus random traffic, checked against
// a tick-count model of frame sequencing and a row/column model of the bar overlay.
module tb_animador_sprites;
  localparam int unsigned MQ = 8;
  localparam int unsigned BQ = 1024;
  localparam int unsigned PQ = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  byte_counter;
  logic [4:0]  estado;
  logic [23:0] niveis;
  logic [19:0] num_quadros;
  logic [4:0]  modo_unico;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic [7:0]  data_to_send;
  logic        quadro_fim;
  bit          rom_force;

  int n_cmp = 0;
  int n_err = 0;

  int          idx_m, prevk_m, m_m;
  logic [15:0] addr_m;
  bit          hit_m, fim_m;
  logic [7:0]  bar_m, data_m;

  animador_sprites #(.PERIODO_QUADRO(PQ)) dut (
    .clk(clk), .reset(reset), .byte_counter(byte_counter), .estado(estado),
    .niveis(niveis), .num_quadros(num_quadros), .modo_unico(modo_unico),
    .mem_addr(mem_addr), .mem_data(mem_data), .data_to_send(data_to_send),
    .quadro_fim(quadro_fim)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [15:0] a);
    return a[7:0] ^ {a[12:8], a[15:13]} ^ 8'hA7;
  endfunction

  assign mem_data = rom_force ? 8'h5A : rom(mem_addr);

  function automatic int kof(input logic [4:0] e);
    int pos = 0;
    int n = 0;
    for (int i = 0; i < 5; i++) if (e[i]) begin n++; pos = i; end
    return (n == 1) ? pos : 0;
  endfunction

  function automatic int frames_of(input int k);
    int n = int'(num_quadros[4*k +: 4]);
    if (n == 0) return 1;
    if (n > MQ) return MQ;
    return n;
  endfunction

  function automatic void bar_ref(input int bc, input logic [23:0] nv,
                                  output bit hit, output logic [7:0] val);
    int row = bc / 8;
    int col = bc % 8;
    int rel, b, lvl, t;
    hit = 0;
    val = 8'h00;
    if (row >= 8 && col >= 1 && col <= 5) begin
      rel = row - 8;
      b   = rel / 10;
      if (b < 3 && (rel % 10) < 5) begin
        lvl = int'(nv[8*b +: 8]);
        if (lvl > 100) lvl = 100;
        t   = 20 * (5 - col);
        hit = 1;
        if (lvl > t + 10) val = 8'hEE;
        else if (lvl > t) val = 8'hE0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int k, c, t, nidx;
    logic [15:0] na;
    k = kof(estado);
    if (reset) begin
      idx_m = 0; prevk_m = 0; m_m = 0; addr_m = '0;
      hit_m = 0; bar_m = '0; data_m = '0; fim_m = 0;
    end else begin
      data_m = hit_m ? bar_m : (rom_force ? 8'h5A : rom(addr_m));
      na = 16'((k * MQ + idx_m) * BQ + int'(byte_counter));
      fim_m = 0;
      if (k != prevk_m) begin
        prevk_m = k; m_m = 0; idx_m = 0;
      end else begin
        m_m++;
        if (m_m % PQ == 0) begin
          c = frames_of(k);
          t = m_m / PQ;
          nidx = modo_unico[k] ? ((t < c - 1) ? t : c - 1) : (t % c);
          fim_m = (nidx != idx_m);
          idx_m = nidx;
        end
      end
      bar_ref(int'(byte_counter), niveis, hit_m, bar_m);
      addr_m = na;
    end
    @(posedge clk); #1;
    chk("mem_addr", 32'(mem_addr), 32'(addr_m));
    chk("quadro_fim", 32'(quadro_fim), 32'(fim_m));
    chk("data_to_send", 32'(data_to_send), 32'(data_m));
  endtask

  task automatic rstep();
    byte_counter = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(64, 199)) : 10'($urandom);
    for (int b = 0; b < 3; b++)
      niveis[8*b +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 105));
    step();
  endtask

  initial begin
    int fims;
    logic [7:0] got [0:6];
    rom_force = 0; reset = 1; estado = 5'b00001; byte_counter = '0;
    niveis = '0; num_quadros = '0; modo_unico = '0;
    idx_m = 0; prevk_m = 0; m_m = 0; addr_m = '0; hit_m = 0; bar_m = '0; data_m = '0; fim_m = 0;

    // reset state
    step(); step();
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_data", 32'(data_to_send), 0);
    chk("rst_fim", 32'(quadro_fim), 0);

    // loop of 7 frames in state 2
    num_quadros = 20'h00700; estado = 5'b00100; reset = 0;
    step();
    fims = 0;
    repeat (28) begin rstep(); fims += int'(quadro_fim); end
    chk("loop7_fim_count", 32'(fims), 7);
    byte_counter = '0; step();
    chk("loop7_wrap_addr", 32'(mem_addr), 16384);

    // one-shot of 8 frames in state 4
    reset = 1; rstep(); reset = 0;
    num_quadros = 20'h80000; modo_unico = 5'b10000; estado = 5'b10000;
    step();
    repeat (28) rstep();
    byte_counter = '0; step();
    chk("oneshot_last_addr", 32'(mem_addr), 39936);
    fims = 0;
    repeat (20) begin rstep(); fims += int'(quadro_fim); end
    chk("oneshot_hold_fim", 32'(fims), 0);

    // bar 0 at level 34 across columns 1..5 of row 8
    reset = 1; step(); reset = 0;
    estado = 5'b00001; num_quadros = '0; modo_unico = '0; niveis = 24'd34;
    for (int i = 0; i < 7; i++) begin
      byte_counter = (i < 5) ? 10'(65 + i) : 10'd0;
      step();
      got[i] = data_to_send;
    end
    chk("bar34_c1", 32'(got[1]), 32'h00);
    chk("bar34_c2", 32'(got[2]), 32'h00);
    chk("bar34_c3", 32'(got[3]), 32'h00);
    chk("bar34_c4", 32'(got[4]), 32'hEE);
    chk("bar34_c5", 32'(got[5]), 32'hEE);
    niveis = 24'd45; byte_counter = 10'd67; step();
    byte_counter = 10'd0; step();
    chk("bar45_c3", 32'(data_to_send), 32'hE0);

    // ROM passthrough at k=2, index=3
    reset = 1; step(); reset = 0;
    num_quadros = 20'h00700; estado = 5'b00100;
    step();
    repeat (12) rstep();
    byte_counter = '0; rom_force = 1; step();
    chk("rom_addr", 32'(mem_addr), 19456);
    byte_counter = 10'd300; step();
    chk("rom_data", 32'(data_to_send), 32'h5A);
    rom_force = 0;

    // state change coinciding with a tick
    reset = 1; step(); reset = 0;
    num_quadros = 20'h03700; estado = 5'b00100;
    step();
    repeat (3) rstep();
    estado = 5'b01000; rstep();
    chk("chg_tick_fim", 32'(quadro_fim), 0);
    byte_counter = '0; step();
    chk("chg_tick_addr", 32'(mem_addr), 24576);
    rstep(); rstep();
    chk("chg_pre_tick_fim", 32'(quadro_fim), 0);
    rstep();
    chk("chg_next_tick_fim", 32'(quadro_fim), 1);

    // reset mid-animation at index 5 (state 0)
    reset = 1; step(); reset = 0;
    num_quadros = 20'h00007; estado = 5'b00001;
    repeat (20) rstep();
    byte_counter = '0; step();
    chk("pre_rst_addr", 32'(mem_addr), 5120);
    reset = 1; rstep();
    chk("mid_rst_addr", 32'(mem_addr), 0);
    chk("mid_rst_data", 32'(data_to_send), 0);
    chk("mid_rst_fim", 32'(quadro_fim), 0);
    reset = 0;
    rstep(); rstep(); rstep();
    chk("rel_pre_tick_fim", 32'(quadro_fim), 0);
    rstep();
    chk("rel_first_tick_fim", 32'(quadro_fim), 1);

    // random rounds: frame config fixed between resets, state hops at random
    repeat (6) begin
      num_quadros = 20'($urandom);
      modo_unico  = 5'($urandom);
      reset = 1; rstep(); reset = 0;
      repeat (8) begin
        estado = ($urandom_range(0, 9) < 7) ? 5'(1 << $urandom_range(0, 4)) : 5'($urandom);
        repeat ($urandom_range(3, 40)) rstep();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/animador_sprites.md
ANIMADOR_SPRITES -- requirements
Module: animador_sprites

Interface
REQ-001 SHALL provide parameter N_ESTADOS, default 5, number of one-hot animation states.
REQ-002 SHALL provide parameter MAX_QUADROS, default 8, frame slots reserved per state in ROM.
REQ-003 SHALL provide parameter BYTES_QUADRO, default 1024, bytes per frame (128x64 OLED, 8 pages).
REQ-004 SHALL provide parameter PERIODO_QUADRO, default 4194304, clock cycles per animation frame.
REQ-005 SHALL provide parameter N_BARRAS, default 3, number of status bars (felicidade, fome, sono).
REQ-006 SHALL provide parameter SEGMENTOS, default 5, segments per bar; PASSO_NIVEL, default 10, level units per half-segment.
REQ-007 SHALL provide parameters BARRA_LINHA0, default 8, first bar row (row = byte_counter/8); BARRA_PASSO, default 10, rows between bars; BARRA_ALTURA, default 5, rows per bar.
REQ-008 Ports; one clock; reset is synchronous and active-high:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- byte_counter  in  clog2(BYTES_QUADRO)  byte index of frame being streamed
- estado  in  N_ESTADOS  one-hot pet state
- niveis  in  8*N_BARRAS  bar b level at bits [8b+7:8b], 0..100
- num_quadros  in  4*N_ESTADOS  frame count of state k at [4k+3:4k]
- modo_unico  in  N_ESTADOS  1 = state k plays once and holds last frame
- mem_addr  out  clog2(N_ESTADOS*MAX_QUADROS*BYTES_QUADRO)  ROM address, registered
- mem_data  in  8  ROM byte, valid one cycle after mem_addr
- data_to_send  out  8  byte to display driver
- quadro_fim  out  1  one-cycle pulse on frame index advance

Function
REQ-009 Frame timer SHALL count 0..PERIODO_QUADRO-1 and wrap; wrap cycle is the "tick".
REQ-010 State index k SHALL be the position of the set bit of estado; zero or multi-hot estado SHALL map to k=0.
REQ-011 Effective frame count SHALL be num_quadros[k], with 0 treated as 1 and values above MAX_QUADROS clamped to MAX_QUADROS.
REQ-012 On tick, loop mode: index <= (index+1) mod count; one-shot mode: index increments until count-1, then holds.
REQ-013 quadro_fim SHALL pulse for exactly the cycle following a tick that changed the index; never when held or count=1.
REQ-014 When k differs from the registered previous k, index and timer SHALL clear to 0 that cycle; this overrides a simultaneous tick and suppresses quadro_fim.
REQ-015 mem_addr SHALL register (k*MAX_QUADROS + index)*BYTES_QUADRO + byte_counter on every clock.
REQ-016 data_to_send SHALL have 2-cycle latency from byte_counter: the bar decision is pipelined one stage to align with mem_data.
REQ-017 Byte in bar b SHALL be row in [BARRA_LINHA0+b*BARRA_PASSO, +BARRA_ALTURA-1] and column c=byte_counter%8 in 1..SEGMENTOS.
REQ-018 Bar byte for segment c, with t=2*(SEGMENTOS-c)*PASSO_NIVEL: 8'hEE if level > t+PASSO_NIVEL; else 8'hE0 if level > t; else 8'h00.
REQ-019 Bytes outside all bars SHALL output mem_data; bars beyond the frame SHALL be ignored.
REQ-020 Level arithmetic SHALL be unsigned 8-bit; levels above 100 behave as 100.

Reset
REQ-021 While reset=1: timer=0, every index=0, previous k=0, mem_addr=0, data_to_send=0, quadro_fim=0; pipeline contents discarded.
REQ-022 Reset asserted mid-animation SHALL restart at frame 0 with a full PERIODO_QUADRO before the first tick after release.

Verification (PERIODO_QUADRO=4, defaults otherwise)
REQ-023 estado=5'b00100, num_quadros[2]=7, loop -> index 0,1..6,0 every 4 cycles; quadro_fim pulses 7 times per cycle of 7 frames.
REQ-024 estado=5'b10000, num_quadros[4]=8, modo_unico[4]=1 -> index reaches 7 after 28 cycles, holds; quadro_fim silent afterwards.
REQ-025 niveis bar0=34, byte_counter=65..69 -> data_to_send 00,00,00,EE,EE two cycles later; level 45 at byte 67 -> E0.
REQ-026 byte_counter=0, k=2, index=3, mem_data returns 8'h5A -> mem_addr=19456 next cycle, data_to_send=8'h5A two cycles after input.
REQ-027 estado change coinciding with tick -> index=0, no quadro_fim, next tick exactly 4 cycles later.
REQ-028 reset pulsed at index 5 -> all outputs 0 next cycle, index 0, first tick 4 cycles after release.
